// File: rtl/param_memory.sv
// Single-port memory slave with byte strobes, out-of-range error reporting and a
// back-pressurable response channel; one transaction is outstanding at a time.
module param_memory #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int RD_LATENCY = 2,
   parameter int RESET_MEM  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [WIDTH/8-1:0]    wstrb_i,
   output logic                  rvalid_o,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  rerr_o,
   input  logic                  rready_i
);

   localparam int NBYTES = WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic               ready_q, ready_d;
   logic               rvalid_q, rvalid_d;
   logic               rerr_q, rerr_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic [WIDTH-1:0]   pend_data_q, pend_data_d;
   logic               pend_err_q, pend_err_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [WIDTH-1:0]   mem_d [DEPTH];

   logic               accept;
   logic               in_range;
   logic [WIDTH-1:0]   rd_word;

   // Full-width compare: addresses beyond DEPTH never alias onto real words.
   always_comb begin
      in_range = 32'(addr_i) < DEPTH;
      rd_word  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_i == ADDR_WIDTH'(i)) begin
            rd_word = mem_q[i];
         end
      end
   end

   assign accept = valid_i && ready_q;

   always_comb begin
      state_d     = state_q;
      ready_d     = ready_q;
      rvalid_d    = rvalid_q;
      rerr_d      = rerr_q;
      rdata_d     = rdata_q;
      pend_data_d = pend_data_q;
      pend_err_d  = pend_err_q;
      cnt_d       = cnt_q;
      mem_d       = mem_q;

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               ready_d     = 1'b0;
               pend_err_d  = !in_range;
               pend_data_d = (!wr_rd_i && in_range) ? rd_word : '0;
               cnt_d       = '0;
               if (wr_rd_i) begin
                  state_d = RESP;
                  for (int i = 0; i < DEPTH; i++) begin
                     if (addr_i == ADDR_WIDTH'(i)) begin
                        for (int k = 0; k < NBYTES; k++) begin
                           if (wstrb_i[k]) begin
                              mem_d[i][8*k +: 8] = wdata_i[8*k +: 8];
                           end
                        end
                     end
                  end
               end else begin
                  state_d = (RD_LATENCY > 1) ? RD_WAIT : RESP;
               end
            end
         end

         RD_WAIT: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(RD_LATENCY - 2)) begin
               state_d = RESP;
            end
         end

         RESP: begin
            // First RESP cycle presents the response; later cycles wait for the handshake.
            if (!rvalid_q) begin
               rvalid_d = 1'b1;
               rdata_d  = pend_data_q;
               rerr_d   = pend_err_q;
            end else if (rready_i) begin
               rvalid_d = 1'b0;
               rerr_d   = 1'b0;
               ready_d  = 1'b1;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         rvalid_q    <= 1'b0;
         rerr_q      <= 1'b0;
         rdata_q     <= '0;
         pend_data_q <= '0;
         pend_err_q  <= 1'b0;
         cnt_q       <= '0;
         if (RESET_MEM != 0) begin
            mem_q <= '{default: '0};
         end
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rvalid_q    <= rvalid_d;
         rerr_q      <= rerr_d;
         rdata_q     <= rdata_d;
         pend_data_q <= pend_data_d;
         pend_err_q  <= pend_err_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
      end
   end

   assign ready_o  = ready_q;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign rerr_o   = rerr_q;

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: three instances (default, DEPTH=10/latency 4/retained memory,
// DEPTH=10/latency 1) driven by directed and random transactions against a word-array model.
module tb_param_memory;

   logic        clk;
   logic        rst    [3];
   logic        valid  [3];
   logic        ready  [3];
   logic        wr     [3];
   logic [5:0]  addr   [3];
   logic [31:0] wdata  [3];
   logic [3:0]  wstrb  [3];
   logic        rvalid [3];
   logic [31:0] rdata  [3];
   logic        rerr   [3];
   logic        rready [3];

   int depthOf [3] = '{16, 10, 10};
   int latOf   [3] = '{2, 4, 1};
   int rmOf    [3] = '{1, 0, 1};
   int awMax   [3] = '{63, 15, 15};

   logic [31:0] model [3][16];
   int testCount = 0;
   int failCount = 0;

   param_memory #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(6), .RD_LATENCY(2), .RESET_MEM(1)) u0 (
      .clk_i(clk), .rst_i(rst[0]), .valid_i(valid[0]), .ready_o(ready[0]), .wr_rd_i(wr[0]),
      .addr_i(addr[0]), .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .rerr_o(rerr[0]), .rready_i(rready[0]));

   param_memory #(.WIDTH(32), .DEPTH(10), .ADDR_WIDTH(4), .RD_LATENCY(4), .RESET_MEM(0)) u1 (
      .clk_i(clk), .rst_i(rst[1]), .valid_i(valid[1]), .ready_o(ready[1]), .wr_rd_i(wr[1]),
      .addr_i(addr[1][3:0]), .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .rerr_o(rerr[1]), .rready_i(rready[1]));

   param_memory #(.WIDTH(32), .DEPTH(10), .ADDR_WIDTH(4), .RD_LATENCY(1), .RESET_MEM(1)) u2 (
      .clk_i(clk), .rst_i(rst[2]), .valid_i(valid[2]), .ready_o(ready[2]), .wr_rd_i(wr[2]),
      .addr_i(addr[2][3:0]), .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .rerr_o(rerr[2]), .rready_i(rready[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One full transaction on instance idx; returns at a negedge with the instance idle again.
   task automatic applyStimulus(input int idx, input bit isWrite, input int a, input logic [31:0] d,
                                input logic [3:0] s, input int hold, input string tag);
      bit          inRange;
      logic [31:0] expData;
      int          expLat;
      int          lat;
      int          n;
      inRange = a < depthOf[idx];
      expData = (isWrite || !inRange) ? 32'h0 : model[idx][a];
      expLat  = isWrite ? 1 : latOf[idx];
      if (isWrite && inRange) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) model[idx][a][8*k +: 8] = d[8*k +: 8];
         end
      end

      n = 0;
      while (ready[idx] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, ".ready_before"}, 32'(ready[idx]), 32'd1);

      rready[idx] = (hold == 0);
      valid[idx]  = 1'b1;
      wr[idx]     = isWrite;
      addr[idx]   = 6'(a);
      wdata[idx]  = d;
      wstrb[idx]  = s;
      @(posedge clk);
      @(negedge clk);
      valid[idx] = 1'b0;
      wdata[idx] = $urandom;
      wstrb[idx] = 4'($urandom);
      checkOutput({tag, ".ready_after_accept"}, 32'(ready[idx]), 32'd0);

      lat = 0;
      while (rvalid[idx] !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".rdata"}, rdata[idx], expData);
      checkOutput({tag, ".rerr"}, 32'(rerr[idx]), 32'(!inRange));

      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({tag, ".hold_rvalid"}, 32'(rvalid[idx]), 32'd1);
         checkOutput({tag, ".hold_rdata"}, rdata[idx], expData);
         checkOutput({tag, ".hold_rerr"}, 32'(rerr[idx]), 32'(!inRange));
         checkOutput({tag, ".hold_ready"}, 32'(ready[idx]), 32'd0);
      end

      rready[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".done_rvalid"}, 32'(rvalid[idx]), 32'd0);
      checkOutput({tag, ".done_ready"}, 32'(ready[idx]), 32'd1);
      checkOutput({tag, ".done_rerr"}, 32'(rerr[idx]), 32'd0);
      checkOutput({tag, ".done_rdata_kept"}, rdata[idx], expData);
   endtask

   // Starts a read, then pulls reset before the response can appear.
   task automatic resetDuringRead(input int idx, input int a);
      rready[idx] = 1'b1;
      valid[idx]  = 1'b1;
      wr[idx]     = 1'b0;
      addr[idx]   = 6'(a);
      @(posedge clk);
      @(negedge clk);
      valid[idx] = 1'b0;
      rst[idx]   = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("midreset.rvalid", 32'(rvalid[idx]), 32'd0);
         checkOutput("midreset.ready", 32'(ready[idx]), 32'd0);
      end
      rst[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset.ready_release", 32'(ready[idx]), 32'd1);
      for (int c = 0; c < 5; c++) begin
         checkOutput("midreset.no_pulse", 32'(rvalid[idx]), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      if (rmOf[idx] != 0) begin
         for (int i = 0; i < 16; i++) model[idx][i] = 32'h0;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b0; valid[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0;
         wdata[i] = '0; wstrb[i] = '0; rready[i] = 1'b1;
         for (int w = 0; w < 16; w++) model[i][w] = 32'h0;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput("reset.ready", 32'(ready[i]), 32'd0);
         checkOutput("reset.rvalid", 32'(rvalid[i]), 32'd0);
         checkOutput("reset.rdata", rdata[i], 32'h0);
         checkOutput("reset.rerr", 32'(rerr[i]), 32'd0);
         rst[i] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) checkOutput("reset.ready_rise", 32'(ready[i]), 32'd1);

      for (int a = 0; a < 16; a++) applyStimulus(0, 1'b0, a, 32'h0, 4'h0, 0, "u0.clear_read");
      for (int a = 0; a < 10; a++) applyStimulus(2, 1'b0, a, 32'h0, 4'h0, 0, "u2.clear_read");
      for (int a = 0; a < 10; a++) applyStimulus(1, 1'b1, a, $urandom, 4'hF, 0, "u1.init_write");

      applyStimulus(0, 1'b1, 3, 32'hAABBCCDD, 4'hF, 0, "u0.strobe_full");
      applyStimulus(0, 1'b1, 3, 32'h11223344, 4'h5, 0, "u0.strobe_partial");
      applyStimulus(0, 1'b0, 3, 32'h0, 4'hF, 0, "u0.strobe_read");
      applyStimulus(0, 1'b0, 3, 32'h0, 4'h0, 5, "u0.backpressure");
      applyStimulus(0, 1'b1, 7, 32'hDEADBEEF, 4'h0, 1, "u0.zero_strobe");
      applyStimulus(0, 1'b0, 7, 32'h0, 4'h0, 0, "u0.zero_strobe_read");
      applyStimulus(0, 1'b1, 40, 32'hFFFFFFFF, 4'hF, 0, "u0.oor_write");
      applyStimulus(0, 1'b0, 16, 32'h0, 4'h0, 0, "u0.oor_read");

      for (int i = 1; i < 3; i++) begin
         applyStimulus(i, 1'b1, 12, 32'hFFFFFFFF, 4'hF, 0, "oor_write");
         applyStimulus(i, 1'b0, 12, 32'h0, 4'h0, 2, "oor_read");
         for (int a = 0; a < 10; a++) applyStimulus(i, 1'b0, a, 32'h0, 4'h0, 0, "oor_unchanged");
      end

      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 40; n++) begin
            int a;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, awMax[i]))
                                            : int'($urandom_range(0, depthOf[i] - 1));
            applyStimulus(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)), "random");
         end
      end

      applyStimulus(1, 1'b1, 5, 32'h12345678, 4'hF, 0, "u1.pre_reset_write");
      resetDuringRead(1, 5);
      applyStimulus(1, 1'b0, 5, 32'h0, 4'h0, 0, "u1.retained_read");
      for (int a = 0; a < 10; a++) applyStimulus(1, 1'b0, a, 32'h0, 4'h0, 0, "u1.retained_sweep");

      applyStimulus(0, 1'b1, 5, 32'h12345678, 4'hF, 0, "u0.pre_reset_write");
      resetDuringRead(0, 5);
      applyStimulus(0, 1'b0, 5, 32'h0, 4'h0, 0, "u0.cleared_read");
      applyStimulus(0, 1'b0, 3, 32'h0, 4'h0, 0, "u0.cleared_read3");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
- Next-generation single-port memory slave with parametrised width, depth and read latency.
- Adds per-byte write strobes, out-of-range address error reporting, and a back-pressurable response channel.
- Exactly one transaction is outstanding at a time.
- Sits behind a master on the valid/ready request interface; every accepted request returns exactly one response beat.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 16, number of words; need not be a power of two
ADDR_WIDTH, 6, address bus width; 2**ADDR_WIDTH >= DEPTH
RD_LATENCY, 2, cycles from read accept to response valid; legal range 1..4
RESET_MEM, 1, 1 = clear array on reset; 0 = retain contents across reset

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-low
valid_i  in  1  request valid
ready_o  out  1  slave can accept a request
wr_rd_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  word address
wdata_i  in  WIDTH  write data
wstrb_i  in  WIDTH/8  byte enables; bit k covers wdata_i[8k+7:8k]
rvalid_o  out  1  response valid
rdata_o  out  WIDTH  read data (0 for write responses)
rerr_o  out  1  response error: address >= DEPTH
rready_i  in  1  master accepts the response

Behaviour:
- Reset (rst_i==0 at a rising edge):
  - ready_o=0, rvalid_o=0, rdata_o=0, rerr_o=0, state=IDLE, latency counter=0.
  - If RESET_MEM==1, all words are cleared to 0.
  - ready_o rises at the first edge with rst_i==1.
- Reset mid-operation: any in-flight or pending response is dropped. A write accepted before reset persists only if RESET_MEM==0.
- All outputs are registered.
- Accept: a request is accepted at an edge where valid_i && ready_o. At the same edge ready_o is cleared, and addr_i, wr_rd_i, wdata_i and wstrb_i are captured.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - ready_o=1.
  - On a write accept: go to RESP.
  - On a read accept: go to RD_WAIT if RD_LATENCY>1, else RESP.
- Write accept:
  - In-range address: each byte k with wstrb_i[k]==1 is updated at the accept edge.
  - wstrb_i==0: no change, normal response.
  - addr_i >= DEPTH: array untouched, rerr_o=1.
  - Response: rvalid_o=1 from the edge after accept, with rdata_o=0.
- Read accept:
  - The word is sampled at the accept edge.
  - The counter counts RD_LATENCY-1 cycles in RD_WAIT.
  - rvalid_o is set at accept edge + RD_LATENCY.
  - Out-of-range read: rdata_o=0, rerr_o=1, same latency.
  - wstrb_i is ignored on reads.
- RESP:
  - rvalid_o, rdata_o and rerr_o are held stable while rready_i==0, for any number of cycles.
  - At the edge with rready_i==1: rvalid_o=0, rerr_o=0, ready_o=1, go to IDLE. rdata_o keeps its last value.
- Throughput: at most one transaction per RD_LATENCY+2 cycles for reads and per 3 cycles for writes. No pipelining and no read/write hazard, since requests are strictly serialised.
- valid_i while ready_o==0: ignored. The master must hold the request.
- Address width rule: addr_i is compared against DEPTH at full ADDR_WIDTH; there is no wrap-around.

Test Plan:
- Reset then idle: rst_i=0 for 2 edges, release -> ready_o=1 after 1 edge; reads of addr 0..DEPTH-1 return 0 with rerr_o=0 (RESET_MEM=1).
- Strobed write: write addr 3 data 0xAABBCCDD strb 0xF, then write addr 3 data 0x11223344 strb 0x5 -> read addr 3 returns 0xAA22CC44, rvalid_o exactly RD_LATENCY edges after accept.
- Back-pressure: read addr 3 with rready_i=0 for 5 cycles -> rvalid_o=1 and rdata_o=0xAA22CC44 stable throughout, ready_o=0; rready_i=1 -> rvalid_o=0 and ready_o=1 next edge.
- Out of range: DEPTH=10, ADDR_WIDTH=4; write addr 12 data 0xFFFFFFFF -> rerr_o=1; read addr 12 -> rerr_o=1, rdata_o=0; all words 0..9 unchanged.
- Latency sweep: RD_LATENCY=1 and 4 -> read response at accept+1 and accept+4 respectively; write response always at accept+1.
- Reset mid-read: assert rst_i during RD_WAIT -> no rvalid_o pulse; with RESET_MEM=0, a prior write to addr 5 (0x12345678) reads back unchanged after reset.
